udp_tx_packetizer: RTL and testbench

Converts the raw outbound byte stream (tx_payload_data/tx_payload_ready) into UDP datagrams for the udp_complete s_udp_* input; it is the transmit counterpart of the RX payload FIFO path. Bytes are buffered until MAX_PAYLOAD is reached, flush is asserted, or the stream idles for TIMEOUT_CYCLES. The block then issues one UDP header with the exact length, followed by the buffered payload with tlast on the final byte. Runs in the 125 MHz logic domain.

---
 rtl/udp_tx_pkg.sv | 23 ++
 rtl/udp_tx_buf_ram.sv | 23 ++
 rtl/udp_tx_packetizer.sv | 188 ++++++++++++++++++
 tb/tb_udp_tx_packetizer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit packetizer.
package udp_tx_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int unsigned UDP_HDR_LEN = 8;
  localparam int unsigned DEFAULT_TTL = 64;
  localparam int unsigned LEN_W       = 16;

  // Header fields captured when a datagram closes.
  typedef struct packed {
    logic [31:0]      source_ip;
    logic [31:0]      dest_ip;
    logic [15:0]      source_port;
    logic [15:0]      dest_port;
    logic [LEN_W-1:0] length;
  } udp_hdr_t;

endpackage

// File: rtl/udp_tx_buf_ram.sv
// Simple dual-port byte buffer with registered read; a read port that is not
// enabled holds its last output.
module udp_tx_buf_ram #(
  parameter int unsigned DEPTH   = 1472,
  parameter int unsigned ADDR_W  = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_tx_packetizer.sv
// Buffers an outbound byte stream and emits it as UDP datagrams: one header
// with the exact length, then the buffered payload with tlast on the final byte.
module udp_tx_packetizer
  import udp_tx_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD    = 1472,
  parameter int unsigned TIMEOUT_CYCLES = 125000,
  parameter int unsigned IP_TTL         = DEFAULT_TTL,
  parameter int unsigned ADDR_WIDTH     = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_flush,
  input  logic [31:0] cfg_source_ip,
  input  logic [31:0] cfg_dest_ip,
  input  logic [15:0] cfg_source_port,
  input  logic [15:0] cfg_dest_port,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_udp_ip_dscp,
  output logic [1:0]  m_udp_ip_ecn,
  output logic [7:0]  m_udp_ip_ttl,
  output logic [31:0] m_udp_ip_source_ip,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
  output logic        busy,
  output logic [31:0] pkt_count
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RAM_AW  = (MAX_PAYLOAD <= 1) ? 1 : $clog2(MAX_PAYLOAD);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(MAX_PAYLOAD);
  localparam logic [TIMER_W-1:0]    TMO_CNT = TIMER_W'(TIMEOUT_CYCLES);

  state_t                state;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] count_inc;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [TIMER_W-1:0]    timer;
  udp_hdr_t              hdr;
  logic                  ram_pend;
  logic                  ram_last;
  logic [7:0]            rd_data;
  logic                  accept;
  logic                  close;
  logic                  timer_run;
  logic                  rd_en;
  logic                  out_load;
  logic                  out_fire;

  assign m_udp_ip_dscp            = '0;
  assign m_udp_ip_ecn             = '0;
  assign m_udp_ip_ttl             = 8'(IP_TTL);
  assign m_udp_checksum           = '0;
  assign m_udp_payload_axis_tuser = 1'b0;
  assign m_udp_ip_source_ip       = hdr.source_ip;
  assign m_udp_ip_dest_ip         = hdr.dest_ip;
  assign m_udp_source_port        = hdr.source_port;
  assign m_udp_dest_port          = hdr.dest_port;
  assign m_udp_length             = hdr.length;

  udp_tx_buf_ram #(
    .DEPTH  (MAX_PAYLOAD),
    .ADDR_W (RAM_AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (count[RAM_AW-1:0]),
    .wr_data (s_data),
    .rd_en   (rd_en),
    .rd_addr (rd_idx[RAM_AW-1:0]),
    .rd_data (rd_data)
  );

  // Fill-side close detection and read-side prefetch control.
  always_comb begin
    accept    = 1'b0;
    count_inc = count;
    timer_run = 1'b0;
    close     = 1'b0;
    rd_en     = 1'b0;
    out_fire  = m_udp_payload_axis_tvalid && m_udp_payload_axis_tready;
    out_load  = ram_pend && (!m_udp_payload_axis_tvalid || m_udp_payload_axis_tready);
    case (state)
      FILL: begin
        accept    = s_valid && s_ready;
        count_inc = count + ADDR_WIDTH'(accept);
        timer_run = (TIMEOUT_CYCLES != 0) && !accept && (count != '0) && (timer != TMO_CNT);
        close     = (count_inc != '0) &&
                    ((count_inc == MAX_CNT) || s_flush ||
                     ((TIMEOUT_CYCLES != 0) && !accept && (timer == TMO_CNT)));
      end
      HDR:     rd_en = m_udp_hdr_ready;
      SEND:    rd_en = (rd_idx < count) && (!ram_pend || out_load);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                     <= FILL;
      count                     <= '0;
      timer                     <= '0;
      rd_idx                    <= '0;
      hdr                       <= '0;
      ram_pend                  <= 1'b0;
      ram_last                  <= 1'b0;
      s_ready                   <= 1'b0;
      busy                      <= 1'b0;
      m_udp_hdr_valid           <= 1'b0;
      m_udp_payload_axis_tvalid <= 1'b0;
      m_udp_payload_axis_tlast  <= 1'b0;
      m_udp_payload_axis_tdata  <= '0;
      pkt_count                 <= '0;
    end else begin
      // RAM output acts as the skid stage between buffer and output register.
      if (rd_en) begin
        rd_idx   <= rd_idx + ADDR_WIDTH'(1);
        ram_last <= (rd_idx == count - ADDR_WIDTH'(1));
        ram_pend <= 1'b1;
      end else if (out_load) begin
        ram_pend <= 1'b0;
      end

      case (state)
        FILL: begin
          if (accept) begin
            count <= count_inc;
            timer <= '0;
          end else if (timer_run) begin
            timer <= timer + TIMER_W'(1);
          end
          if (close) begin
            state           <= HDR;
            busy            <= 1'b1;
            s_ready         <= 1'b0;
            m_udp_hdr_valid <= 1'b1;
            hdr <= '{source_ip:   cfg_source_ip,
                     dest_ip:     cfg_dest_ip,
                     source_port: cfg_source_port,
                     dest_port:   cfg_dest_port,
                     length:      LEN_W'(count_inc) + LEN_W'(UDP_HDR_LEN)};
          end else begin
            s_ready <= (count_inc < MAX_CNT);
          end
        end
        HDR: begin
          if (m_udp_hdr_ready) begin
            m_udp_hdr_valid <= 1'b0;
            state           <= SEND;
          end
        end
        SEND: begin
          if (out_load) begin
            m_udp_payload_axis_tvalid <= 1'b1;
            m_udp_payload_axis_tdata  <= rd_data;
            m_udp_payload_axis_tlast  <= ram_last;
          end else if (out_fire) begin
            m_udp_payload_axis_tvalid <= 1'b0;
            m_udp_payload_axis_tlast  <= 1'b0;
          end
          if (out_fire && m_udp_payload_axis_tlast) begin
            state     <= FILL;
            busy      <= 1'b0;
            count     <= '0;
            timer     <= '0;
            rd_idx    <= '0;
            s_ready   <= 1'b1;
            pkt_count <= pkt_count + 32'd1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Randomized scoreboard bench for udp_tx_packetizer: a queue-based datagram
// model fed by the driver, checked by an independent sink monitor.
module tb_udp_tx_packetizer;

  localparam int unsigned MAXP = 16;
  localparam int unsigned TMO  = 10;
  localparam int unsigned TTL  = 64;

  typedef struct packed {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
  } exp_hdr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid, s_ready, s_flush;
  logic [31:0] cfg_source_ip, cfg_dest_ip;
  logic [15:0] cfg_source_port, cfg_dest_port;
  logic        m_udp_hdr_valid, m_udp_hdr_ready;
  logic [5:0]  m_udp_ip_dscp;
  logic [1:0]  m_udp_ip_ecn;
  logic [7:0]  m_udp_ip_ttl;
  logic [31:0] m_udp_ip_source_ip, m_udp_ip_dest_ip;
  logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
  logic [7:0]  tdata;
  logic        tvalid, tready, tlast, tuser;
  logic        busy;
  logic [31:0] pkt_count;

  always #4 clk = ~clk;

  udp_tx_packetizer #(
    .MAX_PAYLOAD    (MAXP),
    .TIMEOUT_CYCLES (TMO),
    .IP_TTL         (TTL)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_data                    (s_data),
    .s_valid                   (s_valid),
    .s_ready                   (s_ready),
    .s_flush                   (s_flush),
    .cfg_source_ip             (cfg_source_ip),
    .cfg_dest_ip               (cfg_dest_ip),
    .cfg_source_port           (cfg_source_port),
    .cfg_dest_port             (cfg_dest_port),
    .m_udp_hdr_valid           (m_udp_hdr_valid),
    .m_udp_hdr_ready           (m_udp_hdr_ready),
    .m_udp_ip_dscp             (m_udp_ip_dscp),
    .m_udp_ip_ecn              (m_udp_ip_ecn),
    .m_udp_ip_ttl              (m_udp_ip_ttl),
    .m_udp_ip_source_ip        (m_udp_ip_source_ip),
    .m_udp_ip_dest_ip          (m_udp_ip_dest_ip),
    .m_udp_source_port         (m_udp_source_port),
    .m_udp_dest_port           (m_udp_dest_port),
    .m_udp_length              (m_udp_length),
    .m_udp_checksum            (m_udp_checksum),
    .m_udp_payload_axis_tdata  (tdata),
    .m_udp_payload_axis_tvalid (tvalid),
    .m_udp_payload_axis_tready (tready),
    .m_udp_payload_axis_tlast  (tlast),
    .m_udp_payload_axis_tuser  (tuser),
    .busy                      (busy),
    .pkt_count                 (pkt_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  exp_hdr_t   exp_hdr_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] cur[$];
  int         exp_closed = 0;
  int         rem = 0;
  int         rx_bytes = 0;
  int         mode = 0;
  bit         rand_cfg = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a datagram is whatever bytes were accepted since the last close.
  task automatic model_close();
    exp_hdr_t h;
    h.sip = cfg_source_ip;
    h.dip = cfg_dest_ip;
    h.sp  = cfg_source_port;
    h.dp  = cfg_dest_port;
    h.len = 16'(cur.size() + 8);
    exp_hdr_q.push_back(h);
    foreach (cur[i]) exp_bytes.push_back(cur[i]);
    cur.delete();
    exp_closed++;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic fl);
    int n = 0;
    if (rand_cfg) begin
      cfg_source_ip   = $urandom;
      cfg_dest_ip     = $urandom;
      cfg_source_port = 16'($urandom);
      cfg_dest_port   = 16'($urandom);
    end
    s_data  = d;
    s_valid = 1'b1;
    s_flush = fl;
    while (!s_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("s_ready_wait", 32'(s_ready), 32'd1);
    if (s_ready) begin
      @(posedge clk); #1;
      cur.push_back(d);
      if (cur.size() == MAXP || fl) model_close();
    end
    s_valid = 1'b0;
    s_flush = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_flush = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic flush_only();
    s_valid = 1'b0;
    s_flush = 1'b1;
    @(posedge clk); #1;
    s_flush = 1'b0;
    if (cur.size() > 0) model_close();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_hdr_q.size() != 0 || rem != 0 || busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drain"}, 32'(n < 3000), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    check({name, "_pkt_count"}, pkt_count, 32'(exp_closed));
  endtask

  // Sink monitor: drives ready, pops expectations on every handshake.
  initial begin : monitor
    int       cyc = 0;
    int       hs_cyc = 0;
    int       hdr_wait = 0;
    bit       await_first = 1'b0;
    bit       expect_sready = 1'b0;
    bit       hdr_hold = 1'b0;
    bit       t_hold = 1'b0;
    exp_hdr_t held_h, act_h, e;
    logic [7:0] held_d, eb;
    logic       held_l;
    m_udp_hdr_ready = 1'b0;
    tready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      act_h = {m_udp_ip_source_ip, m_udp_ip_dest_ip, m_udp_source_port,
               m_udp_dest_port, m_udp_length};
      if (!rst) begin
        rem = 0;
        exp_hdr_q.delete();
        exp_bytes.delete();
        await_first = 1'b0;
        expect_sready = 1'b0;
        hdr_hold = 1'b0;
        t_hold = 1'b0;
        hdr_wait = 0;
        m_udp_hdr_ready = 1'b0;
        tready = 1'b0;
      end else begin
        if (expect_sready) begin
          check("s_ready_after_tlast", 32'(s_ready), 32'd1);
          expect_sready = 1'b0;
        end
        if (m_udp_hdr_valid || tvalid) begin
          check("s_ready_low_while_busy", 32'(s_ready), 32'd0);
          check("busy_high", 32'(busy), 32'd1);
        end
        if (hdr_hold) begin
          check("hdr_valid_held", 32'(m_udp_hdr_valid), 32'd1);
          check("hdr_sip_stable", act_h.sip, held_h.sip);
          check("hdr_dip_stable", act_h.dip, held_h.dip);
          check("hdr_ports_stable", {act_h.sp, act_h.dp}, {held_h.sp, held_h.dp});
          check("hdr_len_stable", 32'(act_h.len), 32'(held_h.len));
        end
        if (t_hold)
          check("payload_stable", 32'({tvalid, tlast, tdata}), 32'({1'b1, held_l, held_d}));
        if (await_first && cyc == hs_cyc + 1) check("tvalid_gap", 32'(tvalid), 32'd0);
        if (await_first && cyc == hs_cyc + 2) begin
          check("tvalid_rise", 32'(tvalid), 32'd1);
          await_first = 1'b0;
        end

        case (mode)
          0: begin m_udp_hdr_ready = 1'b1; tready = 1'b1; end
          1: begin
            m_udp_hdr_ready = 1'($urandom_range(0, 1));
            tready = ($urandom_range(0, 3) != 0);
          end
          default: begin
            if (m_udp_hdr_valid) begin
              m_udp_hdr_ready = (hdr_wait >= 20);
              hdr_wait++;
            end else begin
              m_udp_hdr_ready = 1'b0;
            end
            tready = !tready;
          end
        endcase

        if (m_udp_hdr_valid && m_udp_hdr_ready) begin
          n_tests++;
          if (exp_hdr_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_hdr: length 0x%0h, expected no header", m_udp_length);
          end else begin
            e = exp_hdr_q.pop_front();
            check("hdr_sip", act_h.sip, e.sip);
            check("hdr_dip", act_h.dip, e.dip);
            check("hdr_sport", 32'(act_h.sp), 32'(e.sp));
            check("hdr_dport", 32'(act_h.dp), 32'(e.dp));
            check("hdr_length", 32'(act_h.len), 32'(e.len));
            check("hdr_consts", {m_udp_ip_ttl, m_udp_ip_dscp, m_udp_ip_ecn, m_udp_checksum},
                  {8'(TTL), 6'd0, 2'd0, 16'd0});
            rem = int'(e.len) - 8;
          end
          hs_cyc = cyc;
          await_first = 1'b1;
          hdr_wait = 0;
        end

        if (tvalid && tready) begin
          n_tests++;
          if (rem == 0 || exp_bytes.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_payload: byte 0x%0h, expected none", tdata);
          end else begin
            eb = exp_bytes.pop_front();
            check("payload_data", 32'(tdata), 32'(eb));
            check("payload_tlast", 32'(tlast), 32'(rem == 1));
            check("payload_tuser", 32'(tuser), 32'd0);
            rem--;
            rx_bytes++;
          end
          if (tlast) expect_sready = 1'b1;
        end

        hdr_hold = m_udp_hdr_valid && !m_udp_hdr_ready;
        held_h   = act_h;
        t_hold   = tvalid && !tready;
        held_d   = tdata;
        held_l   = tlast;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n;
    int rx0;
    rst = 1'b0;
    s_valid = 1'b0;
    s_flush = 1'b0;
    s_data = '0;
    cfg_source_ip = 32'hC0A8_0001;
    cfg_dest_ip = 32'hC0A8_0002;
    cfg_source_port = 16'h1000;
    cfg_dest_port = 16'h1234;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_valids", 32'({m_udp_hdr_valid, tvalid, tlast, busy}), 32'd0);
    check("rst_pkt_count", pkt_count, 32'd0);
    check("rst_length", 32'(m_udp_length), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("s_ready_after_release", 32'(s_ready), 32'd1);

    // Full packet of MAXP bytes.
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    check("full_s_ready_low", 32'(s_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    wait_drain("full");

    // Flush-closed packet, then a flush on an empty buffer.
    rand_cfg = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 1'(i == 4));
    wait_drain("flush");
    flush_only();
    idle(5);
    check("empty_flush_idle", 32'({busy, m_udp_hdr_valid}), 32'd0);
    check("empty_flush_pkt_count", pkt_count, 32'(exp_closed));

    // Idle timeout closes a partial packet.
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    model_close();
    n = 0;
    while (!m_udp_hdr_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("timeout_latency", 32'(n), 32'd11);
    wait_drain("timeout");

    // Header held off, payload ready toggling.
    mode = 2;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'(i == 5));
    wait_drain("backpressure");
    mode = 0;

    // Reset in the middle of sending a payload.
    rx0 = rx_bytes;
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'(i == 7));
    n = 0;
    while (rx_bytes - rx0 < 3 && n < 200) begin @(posedge clk); #1; n++; end
    check("midsend_reached", 32'(rx_bytes - rx0 >= 3), 32'd1);
    rst = 1'b0;
    cur.delete();
    exp_closed = 0;
    @(posedge clk); #1;
    check("midsend_rst_valids", 32'({m_udp_hdr_valid, tvalid, tlast, busy}), 32'd0);
    check("midsend_rst_pkt_count", pkt_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midsend_s_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i), 1'(i == 3));
    wait_drain("post_reset");

    // Back-to-back stream of 40 bytes: 16 + 16 + 8.
    for (int i = 0; i < 40; i++) send_byte(8'($urandom), 1'(i == 39));
    wait_drain("back_to_back");

    // Randomized traffic with random sink readiness.
    mode = 1;
    for (int i = 0; i < 250; i++) begin
      send_byte(8'($urandom), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) flush_only();
    end
    flush_only();
    wait_drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
